// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer
//   Receive-side HDLC deframer. Samples one line bit per Clk while RxEN is
//   high, detects flags (0x7E) and aborts (0 followed by seven 1s), removes
//   stuffed zeros, and assembles the data between flags into LSB-first bytes.
//
// Ports
//   Clk            sole clock, all logic on posedge
//   Rst            synchronous, active-high reset
//   RxEN           receiver enable; low clears all state and forces outputs 0
//   Rx             serial line, one bit per Clk
//   Rx_FlagDetect  one-cycle pulse, two cycles after the final flag bit
//   Rx_AbortDetect one-cycle pulse, two cycles after the seventh abort 1
//   Rx_ValidFrame  high while a frame is open
//   Rx_Data        assembled byte, valid while Rx_WrBuff is high
//   Rx_WrBuff      one-cycle byte strobe
//   Rx_EoF         one-cycle end-of-frame pulse (coincides with Rx_FlagDetect)
//   Rx_FrameError  closed frame was not a whole number of octets
//   Rx_FrameSize   bytes in current/last frame, saturating at 255
//
// Build option
//   HDLC_RX_FLAG_SHARE_EN  defined: a closing flag also opens the next frame.
//                          undefined: a closing flag returns to IDLE and a
//                          fresh opening flag is required.
module hdlc_rx_deframer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_WrBuff,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic [7:0] Rx_FrameSize
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] win_q, win_d;     // raw sample window, newest in bit 0
  logic [7:0] tag_q, tag_d;     // per-window-bit "is a data bit" marker
  logic [3:0] ones_q, ones_d;   // consecutive ones, saturating at 8
  logic [7:0] shift_q, shift_d; // byte assembler
  logic [2:0] bitcnt_q;
  logic       data_seen_q;
  logic       flag_q, abort_q, valid_q, wr_q, eof_q, ferr_q;
  logic [7:0] data_q, size_q;

  logic flag_det, abort_det, abort_now, stuffed, emit;

  always_comb begin
    flag_det  = (win_q == 8'h7E);
    abort_det = (ones_q == 4'd7);
    // Abort is recognised on the very edge that samples the seventh 1, so
    // the bit leaving the delay line on that edge (last bit of the byte
    // preceding the abort sequence) is never written.
    abort_now = Rx && (ones_q == 4'd6);
    stuffed   = !Rx && (ones_q == 4'd5);
    // The oldest window bit leaves the delay line; on a flag edge that bit is
    // the flag's own leading 0 and is dropped.
    emit      = tag_q[7] && !flag_det && !abort_now;
    win_d     = {win_q[6:0], Rx};
    shift_d   = {win_q[7], shift_q[7:1]};

    if (!Rx)                 ones_d = 4'd0;
    else if (ones_q == 4'd8) ones_d = 4'd8;
    else                     ones_d = ones_q + 4'd1;

    // On a flag, everything already in the window is flag material and is
    // untagged; the bit being sampled now is the first candidate data bit.
    if (abort_now)     tag_d = '0;
    else if (flag_det) tag_d = {7'b0, !stuffed};
    else               tag_d = {tag_q[6:0], !stuffed};
  end

  always_ff @(posedge Clk) begin
    if (Rst || !RxEN) begin
      state_q     <= IDLE;
      win_q       <= '0;
      tag_q       <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      data_seen_q <= 1'b0;
      flag_q      <= 1'b0;
      abort_q     <= 1'b0;
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
      size_q      <= '0;
    end else begin
      win_q   <= win_d;
      tag_q   <= tag_d;
      ones_q  <= ones_d;
      flag_q  <= flag_det;
      abort_q <= abort_det;
      wr_q    <= 1'b0;
      eof_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (flag_det) begin
            state_q     <= ACTIVE;
            valid_q     <= 1'b1;
            size_q      <= '0;
            ferr_q      <= 1'b0;
            bitcnt_q    <= '0;
            data_seen_q <= 1'b0;
          end
        end

        ACTIVE: begin
          if (abort_q) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            bitcnt_q    <= '0;
            data_seen_q <= 1'b0;
          end else if (flag_det) begin
            // A flag with no data since opening is just a shared idle flag.
            if (data_seen_q) begin
              eof_q  <= 1'b1;
              ferr_q <= (bitcnt_q != 3'd0);
`ifndef HDLC_RX_FLAG_SHARE_EN
              state_q <= IDLE;
              valid_q <= 1'b0;
`endif
            end
            bitcnt_q    <= '0;
            data_seen_q <= 1'b0;
          end else begin
`ifdef HDLC_RX_FLAG_SHARE_EN
            // Closing flag doubled as the opening flag: start the new
            // frame's bookkeeping one cycle after Rx_EoF.
            if (eof_q) begin
              size_q <= '0;
              ferr_q <= 1'b0;
            end
`endif
            if (abort_now) begin
              bitcnt_q <= '0;
            end else if (emit) begin
              shift_q     <= shift_d;
              bitcnt_q    <= bitcnt_q + 3'd1;
              data_seen_q <= 1'b1;
              if (bitcnt_q == 3'd7) begin
                data_q <= shift_d;
                wr_q   <= 1'b1;
                if (size_q != 8'hFF) size_q <= size_q + 8'd1;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = abort_q;
  assign Rx_ValidFrame  = valid_q;
  assign Rx_Data        = data_q;
  assign Rx_WrBuff      = wr_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_FrameSize   = size_q;

endmodule
